// File: rtl/bnn_feat_loader_if.sv
// bnn_feat_loader_if
//   Handshake bundle around the feature loader: the sample stream into the
//   loader and the prediction stream out of it.
//   master : sample source / prediction consumer side
//   slave  : the loader itself
//   s_data/s_valid/s_ready       feature samples, one per accept
//   pred_out/pred_valid/pred_ready captured classifier result
interface bnn_feat_loader_if #(
    parameter int FEAT_BITS = 4,
    parameter int PW        = 3
);
    logic [FEAT_BITS-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [PW-1:0]        pred_out;
    logic                 pred_valid;
    logic                 pred_ready;

    modport master (
        output s_data, s_valid, pred_ready,
        input  s_ready, pred_out, pred_valid
    );

    modport slave (
        input  s_data, s_valid, pred_ready,
        output s_ready, pred_out, pred_valid
    );
endinterface

// File: rtl/bnn_feat_loader.sv
// bnn_feat_loader
//   Streaming front end for a sequential BNN classifier. Packs FEAT_CNT
//   samples into the parallel features bus, commits it in one step, pulses
//   cls_start, waits SETTLE_CYCLES clocks and hands the classifier's
//   prediction out over a valid/ready handshake.
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-low reset
//   bus        bnn_feat_loader_if.slave (sample in, prediction out)
//   features   committed vector, feature i at [i*FEAT_BITS +: FEAT_BITS]
//   cls_start  one-cycle restart pulse to the classifier
//   prediction classifier result, sampled at the end of the settle window
//   hist_count per-class handshake counters (only with BNN_LOADER_HIST_EN)
// Build option
//   BNN_LOADER_HIST_EN : adds saturating per-class prediction counters.
module bnn_feat_loader #(
    parameter int FEAT_CNT      = 12,
    parameter int FEAT_BITS     = 4,
    parameter int CLASS_CNT     = 6,
    parameter int SETTLE_CYCLES = 48,
    parameter int TEST_CNT      = 1000,
    localparam int PW = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1,
    localparam int HW = $clog2(TEST_CNT + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    bnn_feat_loader_if.slave              bus,
    output logic [FEAT_CNT*FEAT_BITS-1:0] features,
    output logic                          cls_start,
    input  logic [PW-1:0]                 prediction
`ifdef BNN_LOADER_HIST_EN
    ,
    output logic [CLASS_CNT*HW-1:0]       hist_count
`endif
);
    localparam int IW = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {LOAD, SETTLE, DONE} state_t;

    state_t state_q, state_d;

    logic [FEAT_CNT-1:0][FEAT_BITS-1:0] stage_q, stage_nxt, feat_q;
    logic [IW-1:0]                      idx_q;
    logic [CW-1:0]                      cnt_q;
    logic                               s_ready_q;
    logic                               start_q;
    logic [PW-1:0]                      pred_q;
    logic                               pvld_q;

    logic accept, last, cnt_last, hs;

    // s_ready is only ever high in LOAD, but qualify anyway so a stray
    // s_valid can never touch the staging register outside LOAD.
    assign accept   = (state_q == LOAD) && bus.s_valid && s_ready_q;
    assign last     = (idx_q == IW'(FEAT_CNT - 1));
    assign cnt_last = (cnt_q == CW'(SETTLE_CYCLES - 1));
    assign hs       = (state_q == DONE) && pvld_q && bus.pred_ready;

    // Staging contents including the sample being accepted this cycle, so
    // the commit can publish the full vector on the same edge.
    always_comb begin
        stage_nxt        = stage_q;
        stage_nxt[idx_q] = bus.s_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= LOAD;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (accept && last) state_d = SETTLE;
            SETTLE:  if (cnt_last)       state_d = DONE;
            DONE:    if (hs)             state_d = LOAD;
            default:                     state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_q   <= '0;
            feat_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
            start_q   <= 1'b0;
            pred_q    <= '0;
            pvld_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    // Comes up after reset on the first active edge; drops
                    // only on the committing accept.
                    s_ready_q <= ~(accept && last);
                    if (accept) begin
                        stage_q <= stage_nxt;
                        if (last) begin
                            feat_q  <= stage_nxt;
                            start_q <= 1'b1;
                            idx_q   <= '0;
                            cnt_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_last) begin
                        pred_q <= prediction;
                        pvld_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (hs) begin
                        pvld_q    <= 1'b0;
                        s_ready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign features       = feat_q;
    assign cls_start      = start_q;
    assign bus.s_ready    = s_ready_q;
    assign bus.pred_out   = pred_q;
    assign bus.pred_valid = pvld_q;

`ifdef BNN_LOADER_HIST_EN
    logic [CLASS_CNT-1:0][HW-1:0] hist_q;

    // One saturating counter per class; out-of-range predictions match no
    // counter and are dropped.
    for (genvar c = 0; c < CLASS_CNT; c++) begin : g_hist
        always_ff @(posedge clk) begin
            if (!rst)
                hist_q[c] <= '0;
            else if (hs && (pred_q == PW'(c)) && (hist_q[c] != {HW{1'b1}}))
                hist_q[c] <= hist_q[c] + 1'b1;
        end
    end

    assign hist_count = hist_q;
`endif
endmodule

// File: tb/tb_bnn_feat_loader.sv
module tb_bnn_feat_loader;
    localparam int FEAT_CNT  = 12;
    localparam int FEAT_BITS = 4;
    localparam int CLASS_CNT = 6;
    localparam int SETTLE    = 48;
    localparam int TEST_CNT  = 1000;
    localparam int PW        = 3;
    localparam int HW        = 10;
    localparam int FW        = FEAT_CNT * FEAT_BITS;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [FW-1:0] features;
    logic          cls_start;
    logic [PW-1:0] prediction = '0;
`ifdef BNN_LOADER_HIST_EN
    logic [CLASS_CNT*HW-1:0] hist_count;
`endif

    bnn_feat_loader_if #(.FEAT_BITS(FEAT_BITS), .PW(PW)) bus ();

    bnn_feat_loader #(
        .FEAT_CNT(FEAT_CNT), .FEAT_BITS(FEAT_BITS), .CLASS_CNT(CLASS_CNT),
        .SETTLE_CYCLES(SETTLE), .TEST_CNT(TEST_CNT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .features(features),
        .cls_start(cls_start), .prediction(prediction)
`ifdef BNN_LOADER_HIST_EN
        , .hist_count(hist_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc    = 0;
    int starts = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cls_start === 1'b1) starts <= starts + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    typedef struct {
        logic [FW-1:0] feats;
        logic [PW-1:0] pred;
        bit            gap;
        int            hold;
    } vec_t;

    typedef struct {
        logic [FW-1:0] feats;
        logic [PW-1:0] pred;
    } exp_t;

    exp_t sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feeds one full vector; returns the cycle stamp of the last accept.
    task automatic send(input logic [FW-1:0] v, input bit gap, output int e0);
        int  i = 0;
        int  n = 0;
        bit  ph = 1'b0;
        bit  acc;
        while (i < FEAT_CNT && n < 100) begin
            bus.s_valid = gap ? ~ph : 1'b1;
            ph          = ~ph;
            bus.s_data  = v[i*FEAT_BITS +: FEAT_BITS];
            acc         = bus.s_valid && bus.s_ready;
            tick();
            if (acc) i++;
            n++;
        end
        bus.s_valid = 1'b0;
        e0 = cyc;
        if (i < FEAT_CNT) chk("send_timeout", 64'(i), 64'(FEAT_CNT));
    endtask

    task automatic run_vec(input logic [FW-1:0] v, input logic [PW-1:0] p,
                           input bit gap, input int hold);
        exp_t e;
        int   e0, st0, n;
        bit   stable;
        e.feats = v;
        e.pred  = p;
        sb.push_back(e);
        prediction = p;
        st0 = starts;
        send(v, gap, e0);
        chk("cls_start_after_commit", 64'(cls_start), 64'd1);
        chk("features_at_commit", 64'(features), 64'(v));
        // Source keeps offering junk during settle; it must be ignored.
        bus.s_valid = 1'b1;
        n = 0;
        while (!bus.pred_valid && n < 200) begin
            bus.s_data = 4'($urandom);
            tick();
            n++;
        end
        bus.s_valid = 1'b0;
        e = sb.pop_front();
        if (!bus.pred_valid) begin
            chk("pred_valid_timeout", 64'(bus.pred_valid), 64'd1);
        end else begin
            chk("settle_latency", 64'(cyc - e0), 64'(SETTLE));
            chk("pred_out", 64'(bus.pred_out), 64'(e.pred));
            chk("features_held", 64'(features), 64'(e.feats));
            chk("cls_start_count", 64'(starts - st0), 64'd1);
            chk("s_ready_low_done", 64'(bus.s_ready), 64'd0);
        end
        // Classifier output moves after capture; pred_out must not.
        prediction = p ^ 3'b111;
        if (hold > 0) begin
            stable = 1'b1;
            bus.s_valid = 1'b1;
            for (int k = 0; k < hold; k++) begin
                bus.s_data = 4'($urandom);
                tick();
                if (bus.pred_valid !== 1'b1 || bus.pred_out !== e.pred ||
                    bus.s_ready !== 1'b0 || features !== e.feats) stable = 1'b0;
            end
            bus.s_valid = 1'b0;
            chk("done_hold_stable", 64'(stable), 64'd1);
        end
        bus.pred_ready = 1'b1;
        tick();
        bus.pred_ready = 1'b0;
        chk("pred_valid_cleared", 64'(bus.pred_valid), 64'd0);
        chk("s_ready_back", 64'(bus.s_ready), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.s_valid = 1'b0;
        tick();
        chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
        chk("rst_features", 64'(features), 64'd0);
        chk("rst_pred_valid", 64'(bus.pred_valid), 64'd0);
        chk("rst_cls_start", 64'(cls_start), 64'd0);
        chk("rst_pred_out", 64'(bus.pred_out), 64'd0);
        rst = 1'b1;
        tick();
        chk("s_ready_after_rst", 64'(bus.s_ready), 64'd1);
    endtask

    vec_t tbl [4];

    initial begin
        int e0, st0;
        bit seen;
        tbl[0] = '{feats: 48'hCBA987654321, pred: 3'd2, gap: 1'b0, hold: 20};
        tbl[1] = '{feats: 48'hCBA987654321, pred: 3'd4, gap: 1'b1, hold: 0};
        tbl[2] = '{feats: 48'h0123456789AB, pred: 3'd0, gap: 1'b0, hold: 3};
        tbl[3] = '{feats: 48'hFFF000FFF000, pred: 3'd5, gap: 1'b1, hold: 0};

        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.pred_ready = 1'b0;

        do_reset();
        for (int t = 0; t < 4; t++)
            run_vec(tbl[t].feats, tbl[t].pred, tbl[t].gap, tbl[t].hold);

        // pred_ready asserted while nothing is pending changes nothing.
        bus.pred_ready = 1'b1;
        tick();
        tick();
        bus.pred_ready = 1'b0;
        chk("idle_ready_s_ready", 64'(bus.s_ready), 64'd1);
        chk("idle_ready_pred_valid", 64'(bus.pred_valid), 64'd0);

        // Reset after 7 accepts: partial vector dropped.
        st0 = starts;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.s_data = 4'hE;
            tick();
        end
        bus.s_valid = 1'b0;
        do_reset();
        chk("abort_no_start", 64'(starts - st0), 64'd0);
        run_vec(48'h5A5A5A5A5A5A, 3'd1, 1'b0, 0);

        // Reset mid-settle: no prediction may ever appear.
        prediction = 3'd3;
        send(48'h111111111111, 1'b0, e0);
        for (int i = 0; i < 10; i++) tick();
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.pred_valid) seen = 1'b1;
        end
        chk("settle_abort_no_pred", 64'(seen), 64'd0);
        chk("settle_abort_features", 64'(features), 64'd0);

`ifdef BNN_LOADER_HIST_EN
        do_reset();
        for (int i = 0; i < 10; i++) run_vec(48'h000000000123, 3'd3, 1'b0, 0);
        run_vec(48'h000000000456, 3'd6, 1'b0, 0);
        for (int c = 0; c < CLASS_CNT; c++)
            chk($sformatf("hist_%0d", c), 64'(hist_count[c*HW +: HW]),
                (c == 3) ? 64'd10 : 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bnn_feat_loader.md
# bnn_feat_loader

Streaming front end for the sequential ROM-weight BNN classifiers.
- Accepts feature samples one at a time over a valid/ready handshake and packs FEAT_CNT of them into the parallel `features` bus.
- Commits the bus in one step, pulses the classifier's restart, waits a fixed settle time, then returns the classifier's `prediction` over a second valid/ready handshake.
- Sits between the sample source (sensor / test-vector ROM) and a `*_bnn*` classifier instance.

## Interface
- FEAT_CNT, 12, features per vector
- FEAT_BITS, 4, bits per feature sample
- CLASS_CNT, 6, number of classes; prediction width PW = $clog2(CLASS_CNT)
- SETTLE_CYCLES, 48, classifier latency in clocks from restart to valid prediction; legal range ≥1
- TEST_CNT, 1000, vectors per run; sizes histogram counters, HW = $clog2(TEST_CNT+1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- s_data  in  FEAT_BITS  feature sample
- s_valid  in  1  sample valid
- s_ready  out  1  loader can accept a sample (registered)
- features  out  FEAT_CNT*FEAT_BITS  committed vector to the classifier; feature i at bits [i*FEAT_BITS +: FEAT_BITS]
- cls_start  out  1  one-cycle active-high pulse; wired to the classifier's reset/restart input
- prediction  in  PW  classifier result
- pred_out  out  PW  captured prediction
- pred_valid  out  1  pred_out valid, held until accepted
- pred_ready  in  1  consumer accepts pred_out
- hist_count  out  CLASS_CNT*HW  per-class counts; present only with BNN_LOADER_HIST_EN

## Operation
- States: LOAD, SETTLE, DONE. Reset state: LOAD.
- Internal: staging register (FEAT_CNT*FEAT_BITS), index idx (0..FEAT_CNT-1), settle counter cnt (0..SETTLE_CYCLES-1).
- LOAD
  - s_ready=1.
  - Each accept (s_valid && s_ready) writes s_data into staging slot idx; idx increments.
  - On the accept with idx==FEAT_CNT-1:
    - `features` <= staging with the new sample merged in.
    - cls_start <= 1.
    - s_ready <= 0, idx <= 0, cnt <= 0.
    - Go to SETTLE.
- SETTLE
  - cnt increments each cycle; cls_start is 0.
  - When cnt==SETTLE_CYCLES-1: pred_out <= prediction, pred_valid <= 1, go to DONE.
- DONE
  - pred_out/pred_valid are held stable.
  - On pred_valid && pred_ready: pred_valid <= 0, s_ready <= 1, go to LOAD.
- `features` changes only at the commit edge; it is stable through SETTLE and DONE and while the next vector is being staged.
- s_valid is ignored outside LOAD (no accept, no data loss at the source because s_ready=0).

## Timing
- Reset (rst=0 at a clock edge): state LOAD, idx=0, cnt=0, staging=0, features=0, s_ready=0, cls_start=0, pred_out=0, pred_valid=0, hist_count=0.
- s_ready rises on the first edge with rst=1.
- Reset mid-vector or mid-settle: partial vector discarded, no cls_start issued, no pred_valid issued, features cleared to 0.
- Last-sample accept at edge E0:
  - cls_start is high for exactly the cycle E0..E1.
  - pred_valid rises at edge E(SETTLE_CYCLES).
- SETTLE_CYCLES=1: prediction is captured at E1, while cls_start is falling.
- Throughput ceiling: one vector per FEAT_CNT + SETTLE_CYCLES + 1 cycles when pred_ready is tied high.
- pred_ready high while pred_valid is low has no effect.

## Configuration
- BNN_LOADER_HIST_EN defined:
  - CLASS_CNT counters, each HW bits wide.
  - Counter[pred_out] increments on each pred handshake; it saturates at 2^HW-1.
  - pred_out ≥ CLASS_CNT is not counted.
  - All counters clear on reset.
- Undefined: hist_count port and counters are absent; all other behaviour is identical.

## Test plan
- Reset release, then samples 0x1..0xC with s_valid constant 1, SETTLE_CYCLES=48 -> features=0xCBA987654321, one cls_start pulse, pred_valid rises exactly 48 edges after the 12th accept.
- s_valid toggling 1/0 every cycle during a vector -> same features as a gap-free run; idx advances only on accepts.
- pred_ready held 0 for 20 cycles in DONE -> pred_out and pred_valid stable, s_ready=0, extra s_valid ignored; pred_ready=1 -> LOAD next cycle.
- rst=0 after 7 accepts, then a full vector -> no pred_valid from the aborted vector; features reflects only the new 12 samples.
- Prediction changes from 2 to 5 on the cycle after capture -> pred_out stays 2 until the handshake.
- With BNN_LOADER_HIST_EN: 10 vectors with classifier returning 3 and 1 vector returning 6 (out of range) -> hist_count[3]=10, all other counts 0.
